// File: rtl/loadstore_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// loadstore_unit: load/store stage driving a 16-bit request/acknowledge bus
// Rev 1.0
// ----------------------------------------------------------------------------
module loadstore_unit #(
  parameter int REG_IDX_W = 6,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 sign_extend,
  input  logic [1:0]           size,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          store_data,
  input  logic [REG_IDX_W-1:0] dest_idx,
  input  logic [1:0]           dest_mask,
  output logic                 busy,
  output logic                 fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [1:0]           mem_be,
  output logic [15:0]          mem_wdata,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] wb_idx,
  output logic [31:0]          wb_val,
  output logic [1:0]           wb_mask
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   load_q;
  logic                   sext_q;
  logic                   addr0_q;
  logic [1:0]             size_q;
  logic [1:0]             dest_mask_q;
  logic [REG_IDX_W-1:0]   dest_idx_q;
  logic [15:0]            wdata_hi_q;
  logic [15:0]            rdata_lo_q;

  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [1:0]             mem_be_q;
  logic [15:0]            mem_wdata_q;
  logic                   fault_q;
  logic                   wb_en_q;
  logic [REG_IDX_W-1:0]   wb_idx_q;
  logic [31:0]            wb_val_q;
  logic [1:0]             wb_mask_q;

  logic                   req_valid;
  logic                   any_strobe;
  logic                   misaligned;
  logic                   illegal;
  logic                   last_ack;
  logic [7:0]             byte_lane;
  logic [31:0]            ld_val_d;

  assign req_valid  = is_load ^ is_store;
  assign any_strobe = is_load | is_store;
  assign misaligned = ((size == 2'd1) && addr[0]) ||
                      ((size == 2'd2) && (addr[1:0] != 2'b00));
  assign illegal    = (is_load & is_store) | (size == 2'd3) | misaligned;

  assign busy = ((state_q == S_IDLE) && req_valid) ||
                (state_q == S_BEAT0) || (state_q == S_BEAT1);

  // The final beat of an access: beat 0 of a byte/half, or beat 1 of a word.
  assign last_ack = mem_ack && (((state_q == S_BEAT0) && (size_q != 2'd2)) ||
                                (state_q == S_BEAT1));

  assign byte_lane = addr0_q ? mem_rdata[15:8] : mem_rdata[7:0];

  always_comb begin
    ld_val_d = {mem_rdata, rdata_lo_q};
    case (size_q)
      2'd0:    ld_val_d = {{24{sext_q & byte_lane[7]}}, byte_lane};
      2'd1:    ld_val_d = {{16{sext_q & mem_rdata[15]}}, mem_rdata};
      default: ld_val_d = {mem_rdata, rdata_lo_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_q      <= 1'b0;
      sext_q      <= 1'b0;
      addr0_q     <= 1'b0;
      size_q      <= 2'd0;
      dest_mask_q <= 2'd0;
      dest_idx_q  <= '0;
      wdata_hi_q  <= 16'h0000;
      rdata_lo_q  <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= 16'h0000;
      fault_q     <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_idx_q    <= '0;
      wb_val_q    <= 32'h0000_0000;
      wb_mask_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_strobe) begin
            if (illegal) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              load_q      <= is_load;
              sext_q      <= sign_extend;
              addr0_q     <= addr[0];
              size_q      <= size;
              dest_mask_q <= dest_mask;
              dest_idx_q  <= dest_idx;
              wdata_hi_q  <= store_data[31:16];
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[ADDR_W-1:1], 1'b0};
              mem_be_q    <= (size == 2'd0) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
              mem_wdata_q <= (size == 2'd0) ? {2{store_data[7:0]}} : store_data[15:0];
              state_q     <= S_BEAT0;
            end
          end
        end
        S_BEAT0: begin
          if (mem_ack && (size_q == 2'd2)) begin
            rdata_lo_q  <= mem_rdata;
            mem_addr_q  <= mem_addr_q + ADDR_W'(2);
            mem_wdata_q <= wdata_hi_q;
            state_q     <= S_BEAT1;
          end
        end
        S_BEAT1: ;
        S_DONE: begin
          wb_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          fault_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (last_ack) begin
        mem_req_q <= 1'b0;
        state_q   <= S_DONE;
        if (load_q) begin
          wb_en_q   <= |dest_mask_q;
          wb_val_q  <= ld_val_d;
          wb_idx_q  <= dest_idx_q;
          wb_mask_q <= dest_mask_q;
        end
      end
    end
  end

  assign fault     = fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_idx    = wb_idx_q;
  assign wb_val    = wb_val_q;
  assign wb_mask   = wb_mask_q;

endmodule
`default_nettype wire
